// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder and its bus-side neighbours:
// default bus widths and the responder FSM state encoding.
package mem_responder_pkg;

   localparam int AWIDTH_DEF = 5;
   localparam int DWIDTH_DEF = 8;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ    = 2'd1;
   localparam logic [1:0] ST_WR_HOLD = 2'd2;

endpackage

// File: rtl/mem_responder_parity_gen.sv
// Even-parity generator: XOR reduction over one data word.
// Used by mem_responder on the write side and the read check side.
module parity_gen #(
   parameter int DWIDTH = 8
) (
   input  logic [DWIDTH-1:0] data,
   output logic              par
);

   assign par = ^data;

endmodule

// File: rtl/mem_responder.sv
// Single-port synchronous memory answering rd/wr strobes on the CPU bus.
// Optional MEM_PARITY_EN adds a stored even-parity bit per word and par_err.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AWIDTH-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic [DWIDTH-1:0] data_in,
   output logic [DWIDTH-1:0] data_out,
   output logic              data_oe,
   output logic              proto_err,
   output logic              par_err
);

   localparam int DEPTH = 2 ** AWIDTH;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] data_out_q, data_out_d;
   logic              proto_err_q, proto_err_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic              do_wr;
   logic              do_rd;

   // One write per wr pulse: WR_HOLD blocks the rest of a wide pulse.
   always_comb begin
      do_wr = wr && (state_q != ST_WR_HOLD);
      do_rd = rd && !wr;
      if (wr) begin
         state_d = ST_WR_HOLD;
      end else if (rd) begin
         state_d = ST_READ;
      end else begin
         state_d = ST_IDLE;
      end
      data_out_d  = do_rd ? mem_q[addr] : data_out_q;
      proto_err_d = proto_err_q | (rd & wr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         data_out_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[addr] <= data_in;
      end
   end

   assign data_out  = data_out_q;
   assign data_oe   = (state_q == ST_READ);
   assign proto_err = proto_err_q;

`ifdef MEM_PARITY_EN
   logic par_mem_q [DEPTH];
   logic wr_par;
   logic rd_par;
   logic par_err_q, par_err_d;

   parity_gen #(.DWIDTH(DWIDTH)) u_wr_par (
      .data (data_in),
      .par  (wr_par)
   );

   parity_gen #(.DWIDTH(DWIDTH)) u_rd_par (
      .data (mem_q[addr]),
      .par  (rd_par)
   );

   always_comb begin
      par_err_d = par_err_q | (do_rd && (rd_par != par_mem_q[addr]));
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         par_mem_q[addr] <= wr_par;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a
// pulse-level behavioural model of the memory.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] addr;
   logic       rd;
   logic       wr;
   logic [7:0] din;
   logic [7:0] data_out;
   logic       data_oe;
   logic       proto_err;
   logic       par_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] m_mem [32];
   logic [7:0] m_dout;
   logic       m_oe;
   logic       m_perr;
   logic       m_wrprev;

   always #5 clk = ~clk;

   mem_responder #(.AWIDTH(5), .DWIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .rd        (rd),
      .wr        (wr),
      .data_in   (din),
      .data_out  (data_out),
      .data_oe   (data_oe),
      .proto_err (proto_err),
      .par_err   (par_err)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dout   = 8'h00;
      m_oe     = 1'b0;
      m_perr   = 1'b0;
      m_wrprev = 1'b0;
   endtask

   // Model: a write happens on the first cycle of each wr pulse;
   // a read happens whenever rd is high without wr.
   task automatic cyc(input logic r, input logic w,
                      input logic [4:0] a, input logic [7:0] d);
      rd   = r;
      wr   = w;
      addr = a;
      din  = d;
      @(posedge clk);
      if (rst) begin
         if (w && !m_wrprev) m_mem[a] = d;
         if (r && !w) m_dout = m_mem[a];
         m_oe = r && !w;
         if (r && w) m_perr = 1'b1;
         m_wrprev = w;
      end
      #1;
      chk("data_out", data_out, m_dout);
      chk("data_oe", 8'(data_oe), 8'(m_oe));
      chk("proto_err", 8'(proto_err), 8'(m_perr));
      chk("par_err", 8'(par_err), 8'h00);
   endtask

   task automatic do_reset();
      rd  = 1'b0;
      wr  = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_async_dout", data_out, 8'h00);
      chk("rst_async_oe", 8'(data_oe), 8'h00);
      chk("rst_async_perr", 8'(proto_err), 8'h00);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst  = 1'b0;
      rd   = 1'b0;
      wr   = 1'b0;
      addr = '0;
      din  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dout", data_out, 8'h00);
      chk("reset_oe", 8'(data_oe), 8'h00);
      chk("reset_proto", 8'(proto_err), 8'h00);
      chk("reset_par", 8'(par_err), 8'h00);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b1, 5'(i), 8'(i * 13 + 7));
         cyc(1'b0, 1'b0, 5'd0, 8'h00);
      end
      cyc(1'b0, 1'b1, 5'd0, 8'h10);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);
      cyc(1'b0, 1'b1, 5'd1, 8'h20);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);
      cyc(1'b0, 1'b1, 5'd2, 8'h30);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);

      cyc(1'b0, 1'b1, 5'd3, 8'hA5);
      cyc(1'b1, 1'b0, 5'd3, 8'h00);
      chk("rd_a5", data_out, 8'hA5);
      chk("rd_a5_oe", 8'(data_oe), 8'h01);
      chk("rd_a5_proto", 8'(proto_err), 8'h00);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);

      cyc(1'b0, 1'b1, 5'd7, 8'h11);
      cyc(1'b0, 1'b1, 5'd7, 8'h22);
      cyc(1'b0, 1'b1, 5'd7, 8'h33);
      cyc(1'b0, 1'b0, 5'd7, 8'h00);
      cyc(1'b1, 1'b0, 5'd7, 8'h00);
      chk("wr_hold_once", data_out, 8'h11);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);

      cyc(1'b1, 1'b0, 5'd0, 8'h00);
      chk("step_a0", data_out, 8'h10);
      cyc(1'b1, 1'b0, 5'd1, 8'h00);
      chk("step_a1", data_out, 8'h20);
      cyc(1'b1, 1'b0, 5'd2, 8'h00);
      chk("step_a2", data_out, 8'h30);
      cyc(1'b0, 1'b0, 5'd2, 8'h00);
      chk("step_oe_fall", 8'(data_oe), 8'h00);
      chk("step_hold", data_out, 8'h30);

      cyc(1'b1, 1'b1, 5'd4, 8'h5C);
      chk("both_proto", 8'(proto_err), 8'h01);
      chk("both_noread", data_out, 8'h30);
      chk("both_oe", 8'(data_oe), 8'h00);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);
      cyc(1'b1, 1'b0, 5'd4, 8'h00);
      chk("both_written", data_out, 8'h5C);
      chk("proto_sticky", 8'(proto_err), 8'h01);

      cyc(1'b1, 1'b0, 5'd3, 8'h00);
      do_reset();
      cyc(1'b1, 1'b0, 5'd3, 8'h00);
      chk("post_reset_a5", data_out, 8'hA5);
      chk("post_reset_proto", 8'(proto_err), 8'h00);
      cyc(1'b0, 1'b0, 5'd0, 8'h00);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end
         cyc(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0),
             5'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
